// File: rtl/fifo_pack_pkg.sv
// Shared types and sizing helpers for the FIFO nibble packer.
// Optional partial-word flush is built when FIFO_PACK_TIMEOUT_EN is defined.
package fifo_pack_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam int PKG_NIBBLE_WIDTH   = 4;
    localparam int PKG_PACK_FACTOR    = 2;
    localparam int PKG_TIMEOUT_CYCLES = 255;

    localparam int OUT_WIDTH = PKG_NIBBLE_WIDTH * PKG_PACK_FACTOR;
    localparam int IDX_WIDTH = $clog2(PKG_PACK_FACTOR);
    localparam int TMR_WIDTH = $clog2(PKG_TIMEOUT_CYCLES + 1);

    function automatic int calc_out_width(input int nibble_width, input int pack_factor);
        return nibble_width * pack_factor;
    endfunction

    function automatic int calc_idx_width(input int pack_factor);
        return $clog2(pack_factor);
    endfunction

    function automatic int calc_tmr_width(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/pack_timeout_timer.sv
// Idle counter for partial-word flush; saturates at TIMEOUT_CYCLES.
// Only instantiated when FIFO_PACK_TIMEOUT_EN is defined.
module pack_timeout_timer
    import fifo_pack_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = PKG_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int TW = calc_tmr_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/fifo_nibble_packer.sv
// Pops nibbles from a FWFT FIFO and packs PACK_FACTOR of them (first in LSBs) into a word.
// Define FIFO_PACK_TIMEOUT_EN to flush idle partial words after TIMEOUT_CYCLES.
module fifo_nibble_packer
    import fifo_pack_pkg::*;
#(
    parameter int NIBBLE_WIDTH   = PKG_NIBBLE_WIDTH,
    parameter int PACK_FACTOR    = PKG_PACK_FACTOR,
    parameter int TIMEOUT_CYCLES = PKG_TIMEOUT_CYCLES
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                fifo_empty,
    input  logic [NIBBLE_WIDTH-1:0]             fifo_read_data,
    output logic                                fifo_read_increment,
    output logic [NIBBLE_WIDTH*PACK_FACTOR-1:0] out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_partial,
    output state_t                              o_dbg_state
);

    localparam int OW = calc_out_width(NIBBLE_WIDTH, PACK_FACTOR);
    localparam int IW = calc_idx_width(PACK_FACTOR);
    localparam logic [IW-1:0] LAST_IDX = IW'(PACK_FACTOR - 1);

    if ((PACK_FACTOR < 2) || (PACK_FACTOR > 8) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
        $error("fifo_nibble_packer: illegal PACK_FACTOR or TIMEOUT_CYCLES");
    end

    state_t          r_state, w_state_n;
    logic [IW-1:0]   r_idx, w_idx_n;
    logic [OW-1:0]   r_data, w_data_n;
    logic            r_valid, w_valid_n;
    logic            r_partial, w_partial_n;
    logic            r_armed;
    logic            w_pop;
    logic            w_expired;

`ifdef FIFO_PACK_TIMEOUT_EN
    // Counter runs only while a partial word sits idle; leaving COLLECT or popping restarts it.
    pack_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_pop || (r_state == HOLD)),
        .i_enable  ((r_state == COLLECT) && (r_idx != '0) && !w_pop),
        .o_expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    // A pending flush wins over a pop so the flushed word never mixes with new data.
    assign w_pop = r_armed && rst_n && !fifo_empty &&
                   (((r_state == COLLECT) && !(w_expired && (r_idx != '0))) ||
                    ((r_state == HOLD) && out_ready));

    always_comb begin
        w_state_n   = r_state;
        w_idx_n     = r_idx;
        w_data_n    = r_data;
        w_valid_n   = r_valid;
        w_partial_n = r_partial;
        case (r_state)
            COLLECT: begin
                if (w_pop) begin
                    w_data_n[int'(r_idx)*NIBBLE_WIDTH +: NIBBLE_WIDTH] = fifo_read_data;
                    if (r_idx == LAST_IDX) begin
                        w_state_n   = HOLD;
                        w_valid_n   = 1'b1;
                        w_partial_n = 1'b0;
                        w_idx_n     = '0;
                    end else begin
                        w_idx_n = r_idx + 1'b1;
                    end
                end else if (w_expired && (r_idx != '0)) begin
                    w_state_n   = HOLD;
                    w_valid_n   = 1'b1;
                    w_partial_n = 1'b1;
                    w_idx_n     = '0;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_n   = COLLECT;
                    w_valid_n   = 1'b0;
                    w_partial_n = 1'b0;
                    w_data_n    = '0;
                    if (w_pop) begin
                        w_data_n[NIBBLE_WIDTH-1:0] = fifo_read_data;
                        w_idx_n = IW'(1);
                    end else begin
                        w_idx_n = '0;
                    end
                end
            end
            default: begin
                w_state_n = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= COLLECT;
            r_idx     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_partial <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_idx     <= w_idx_n;
            r_data    <= w_data_n;
            r_valid   <= w_valid_n;
            r_partial <= w_partial_n;
            r_armed   <= 1'b1;
        end
    end

    assign fifo_read_increment = w_pop;
    assign out_data            = r_data;
    assign out_valid           = r_valid;
    assign out_partial         = r_partial;
    assign o_dbg_state         = r_state;

endmodule
